// File: rtl/mavg_sched_pkg.sv
// Shared types and defaults for the multi-channel moving-average scheduler.
package mavg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DW_DEF        = 16;
    localparam int N_CH_DEF      = 4;
    localparam int TAPS_DEF      = 8;
    localparam int LOG2_TAPS_DEF = 3;
    localparam int ACC_W_DEF     = DW_DEF + LOG2_TAPS_DEF;

    // Sign-extend the low w bits of x to 32 bits; callers truncate to their
    // own accumulator width, so one helper serves every parameterisation.
    function automatic logic [31:0] sext32(input logic [31:0] x, input int w);
        logic [31:0] t;
        t = x << (32 - w);
        return $signed(t) >>> (32 - w);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant,
// searching upward with wrap-around, receives a one-hot grant.
module rr_arbiter
    import mavg_sched_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   last_grant,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [CW-1:0] cand;

    // Walk the channels starting just after the previous winner; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CW'((int'(last_grant) + i) % N_CH);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mavg_channel_scheduler.sv
// Shares one recursive moving-average datapath across N_CH sample channels.
// Each channel keeps a TAPS-deep history, a write pointer and a running sum;
// results come back one at a time, tagged with the channel they belong to.
module mavg_channel_scheduler
    import mavg_sched_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int N_CH      = N_CH_DEF,
    parameter int TAPS      = TAPS_DEF,
    parameter int LOG2_TAPS = LOG2_TAPS_DEF,
    localparam int CW       = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [N_CH-1:0]    in_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_chan,
    input  logic               out_ready,
    output logic               busy
);

    localparam int ACC_W = DW + LOG2_TAPS;

    state_t                   state_reg;
    logic [CW-1:0]            last_grant_reg;
    logic [DW-1:0]            samp_reg;
    logic [CW-1:0]            chan_reg;
    logic                     out_valid_reg;
    logic [DW-1:0]            out_data_reg;
    logic [CW-1:0]            out_chan_reg;

    logic [DW-1:0]            hist_reg [N_CH][TAPS];
    logic [LOG2_TAPS-1:0]     ptr_reg  [N_CH];
    logic signed [ACC_W-1:0]  acc_reg  [N_CH];

    logic [DW-1:0]            samp_arr [N_CH];
    logic [N_CH-1:0]          grant;
    logic [CW-1:0]            grant_idx;
    logic                     grant_any;

    logic [DW-1:0]            hist_old;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DW-1:0]            result;

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic [DW-1:0] x);
        return ACC_W'(sext32(32'(x), DW));
    endfunction

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign samp_arr[gi] = in_data[gi*DW +: DW];
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Grants are offered only while waiting for work and never during a clear.
    assign in_ready = (state_reg == IDLE && !clear) ? grant : '0;

    // Recursive update: add the new sample, drop the one falling out of the window.
    // The window sum of TAPS samples always fits ACC_W bits, and after the
    // arithmetic shift (floor division) the result always fits DW bits.
    assign hist_old = hist_reg[chan_reg][ptr_reg[chan_reg]];
    assign acc_next = acc_reg[chan_reg] + sext_acc(samp_reg) - sext_acc(hist_old);
    assign result   = DW'(acc_next >>> LOG2_TAPS);

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign busy      = (state_reg != IDLE);

    // Control FSM: accept a granted sample, compute for one cycle, hold the result until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= CW'(N_CH - 1);
            samp_reg       <= '0;
            chan_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
        end else if (clear) begin
            state_reg      <= IDLE;
            last_grant_reg <= CW'(N_CH - 1);
            samp_reg       <= '0;
            chan_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        samp_reg       <= samp_arr[grant_idx];
                        chan_reg       <= grant_idx;
                        last_grant_reg <= grant_idx;
                        state_reg      <= CALC;
                    end
                end
                CALC: begin
                    out_data_reg  <= result;
                    out_chan_reg  <= chan_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-channel filter state; only the channel being computed is touched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    hist_reg[c][t] <= '0;
                end
                ptr_reg[c] <= '0;
                acc_reg[c] <= '0;
            end
        end else if (clear) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    hist_reg[c][t] <= '0;
                end
                ptr_reg[c] <= '0;
                acc_reg[c] <= '0;
            end
        end else if (state_reg == CALC) begin
            hist_reg[chan_reg][ptr_reg[chan_reg]] <= samp_reg;
            ptr_reg[chan_reg] <= ptr_reg[chan_reg] + LOG2_TAPS'(1);
            acc_reg[chan_reg] <= acc_next;
        end
    end

endmodule

// File: tb/tb_mavg_channel_scheduler.sv
// Scoreboard bench for mavg_channel_scheduler: stimulus pushes the expected
// {channel, result} pairs, a monitor pops and compares on every handshake.
module tb_mavg_channel_scheduler;

    localparam int DW   = 16;
    localparam int N_CH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [1:0]         out_chan;
    logic               out_ready;
    logic               busy;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   txn    = 0;

    logic [15:0] dc_exp [10];
    logic [3:0]  g;
    logic [3:0]  eg;
    int          last_cyc;
    int          n;

    mavg_channel_scheduler #(
        .DW        (16),
        .N_CH      (4),
        .TAPS      (8),
        .LOG2_TAPS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every accepted result is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual chan=%0d data=0x%04h required none", out_chan, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                txn++;
                $display("txn %0d: chan=%0d data=0x%04h (expected chan=%0d data=0x%04h)",
                         txn, out_chan, out_data, mon_e.ch, mon_e.d);
                chk("out_chan", 32'(out_chan), 32'(mon_e.ch));
                chk("out_data", 32'(out_data), 32'(mon_e.d));
            end
        end
    end

    // Wait (bounded) for a grant on any channel in mask; sampled on the falling edge.
    task automatic wait_grant(input logic [3:0] mask, output logic [3:0] gr);
        bit ok;
        ok = 1'b0;
        gr = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((in_ready & mask) != 0) begin
                ok = 1'b1;
                gr = in_ready;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=none required=mask 0x%0h", mask);
        end
    endtask

    task automatic send(input int ch, input logic [15:0] x, input logic [15:0] y);
        logic [3:0] gr;
        in_data[ch*DW +: DW] = x;
        in_valid[ch] = 1'b1;
        exp_q.push_back(exp_t'{2'(ch), y});
        wait_grant(4'(1 << ch), gr);
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("drain_idle", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        dc_exp = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFF, 16'h4FFF,
                   16'h5FFF, 16'h6FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_chan",  32'(out_chan),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // DC step on ch0 with a free-running consumer: one result every 3 cycles
        in_data[15:0] = 16'h7FFF;
        for (int i = 0; i < 10; i++) exp_q.push_back(exp_t'{2'd0, dc_exp[i]});
        in_valid[0] = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            wait_grant(4'b0001, g);
            if (i > 0) chk("dc_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
        end
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        drain();

        // Impulse on ch1, then two single-sample rounding cases
        pulse_clear();
        send(1, 16'h7FFF, 16'h0FFF);
        for (int i = 0; i < 7; i++) send(1, 16'h0000, 16'h0FFF);
        send(1, 16'h0000, 16'h0000);
        send(1, 16'h0000, 16'h0000);
        drain();
        pulse_clear();
        send(1, 16'hFFF8, 16'hFFFF);
        drain();
        pulse_clear();
        send(1, 16'hFFFF, 16'hFFFF);
        drain();

        // Round-robin with all channels requesting constants 8, 16, 24, 32
        pulse_clear();
        for (int c = 0; c < 4; c++) in_data[c*DW +: DW] = 16'((c + 1) * 8);
        for (int r = 1; r <= 8; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(exp_t'{2'(c), 16'((c + 1) * r)});
        in_valid = 4'hF;
        for (int i = 0; i < 32; i++) begin
            wait_grant(4'hF, g);
            eg = 4'(1 << (i % 4));
            chk("rr_grant", 32'(g), 32'(eg));
        end
        @(posedge clk);
        #1 in_valid = '0;
        drain();

        // Backpressure: result held stable while the consumer stalls
        pulse_clear();
        out_ready = 1'b0;
        in_data[2*DW +: DW] = 16'h0040;
        in_data[3*DW +: DW] = 16'h0080;
        exp_q.push_back(exp_t'{2'd2, 16'h0008});
        exp_q.push_back(exp_t'{2'd3, 16'h0010});
        in_valid = 4'b1100;
        wait_grant(4'b1100, g);
        chk("bp_first_grant", 32'(g), 32'h4);
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid",    32'(out_valid), 32'd1);
            chk("bp_hold_data",     32'(out_data),  32'h0008);
            chk("bp_hold_chan",     32'(out_chan),  32'd2);
            chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_grant(4'b1000, g);
        chk("bp_accept_after_handshake", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid[3] = 1'b0;
        drain();

        // Clear during CALC discards the result and wipes history
        pulse_clear();
        send(0, 16'h0400, 16'h0080);
        drain();
        in_data[15:0] = 16'h0400;
        in_valid[0] = 1'b1;
        wait_grant(4'b0001, g);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        clear = 1'b1;
        chk("clr_busy_in_calc", 32'(busy), 32'd1);
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_busy",      32'(busy),      32'd0);
        send(0, 16'h0800, 16'h0100);
        drain();

        // Asynchronous reset while a result is waiting in OUT
        out_ready = 1'b0;
        in_data[1*DW +: DW] = 16'h0100;
        in_valid[1] = 1'b1;
        wait_grant(4'b0010, g);
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_valid_before", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_busy",      32'(busy),      32'd0);
        chk("ar_out_data",  32'(out_data),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // After reset the round-robin pointer restarts so ch1 beats ch2
        in_data[1*DW +: DW] = 16'h0020;
        in_data[2*DW +: DW] = 16'h0030;
        exp_q.push_back(exp_t'{2'd1, 16'h0004});
        exp_q.push_back(exp_t'{2'd2, 16'h0006});
        in_valid = 4'b0110;
        wait_grant(4'b0110, g);
        chk("ar_first_grant", 32'(g), 32'h2);
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        wait_grant(4'b0100, g);
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
